// File: rtl/blob_frame_feeder.sv
// Captures one thresholded camera frame into bit memory, replays it as a gap-free burst
// to the blob counter, and returns the counter's result (or a timeout) to the control side.
`timescale 1ns/1ps
module blob_frame_feeder #(
    parameter int IMG_COL = 640,
    parameter int IMG_ROW = 480,
    parameter int PIX_W   = 12,
    parameter int TIMEOUT = 1048575
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [PIX_W-1:0] i_thresh,
    input  logic             i_pix_valid,
    input  logic             i_pix_sof,
    input  logic [PIX_W-1:0] i_pix_gray,
    output logic             o_valid,
    output logic             o_seq,
    input  logic             i_blob_valid,
    input  logic [7:0]       i_blob_count,
    output logic             o_busy,
    output logic [7:0]       o_count,
    output logic             o_count_valid,
    output logic             o_timeout
);
    localparam int N  = IMG_COL * IMG_ROW;
    localparam int AW = $clog2(N);
    localparam int WW = 20;

    localparam logic [AW-1:0] WR_LAST   = AW'(N - 1);
    localparam logic [AW-1:0] WR_ONE    = AW'(1);
    localparam logic [AW:0]   RD_END    = (AW + 1)'(N);
    localparam logic [AW:0]   RD_ONE    = (AW + 1)'(1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_CAP, S_PRE, S_STR, S_WAIT} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    wr_addr_q, wr_addr_d;
    logic [AW:0]      rd_addr_q, rd_addr_d;
    logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
    logic [PIX_W-1:0] thr_q, thr_d;
    logic [7:0]       count_q, count_d;
    logic             count_valid_q, count_valid_d;
    logic             timeout_q, timeout_d;

    logic             mem [N];
    logic             mem_we;
    logic             mem_wdata;
    logic [AW-1:0]    mem_waddr;
    logic             mem_re;
    logic [AW-1:0]    mem_raddr;
    logic             mem_rdata;

    logic             pix_bit;
    logic             pix_sof;

    assign pix_bit = (i_pix_gray >= thr_q);
    assign pix_sof = i_pix_valid & i_pix_sof;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= S_IDLE;
            wr_addr_q     <= '0;
            rd_addr_q     <= '0;
            wait_cnt_q    <= '0;
            thr_q         <= '0;
            count_q       <= '0;
            count_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_addr_q     <= wr_addr_d;
            rd_addr_q     <= rd_addr_d;
            wait_cnt_q    <= wait_cnt_d;
            thr_q         <= thr_d;
            count_q       <= count_d;
            count_valid_q <= count_valid_d;
            timeout_q     <= timeout_d;
        end
    end

    // Frame store is deliberately not reset; every burst replays a fully rewritten frame.
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        if (mem_re) begin
            mem_rdata <= mem[mem_raddr];
        end
    end

    always_comb begin
        state_d       = state_q;
        wr_addr_d     = wr_addr_q;
        rd_addr_d     = rd_addr_q;
        wait_cnt_d    = wait_cnt_q;
        thr_d         = thr_q;
        count_d       = count_q;
        count_valid_d = 1'b0;
        timeout_d     = timeout_q;
        mem_we        = 1'b0;
        mem_waddr     = wr_addr_q;
        mem_wdata     = pix_bit;
        mem_re        = 1'b0;
        mem_raddr     = rd_addr_q[AW-1:0];

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    thr_d   = i_thresh;
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                if (pix_sof) begin
                    mem_we    = 1'b1;
                    mem_waddr = '0;
                    wr_addr_d = WR_ONE;
                    state_d   = S_CAP;
                end
            end
            S_CAP: begin
                if (pix_sof) begin
                    mem_we    = 1'b1;
                    mem_waddr = '0;
                    wr_addr_d = WR_ONE;
                end else if (i_pix_valid) begin
                    mem_we    = 1'b1;
                    wr_addr_d = wr_addr_q + 1'b1;
                    if (wr_addr_q == WR_LAST) begin
                        wr_addr_d = '0;
                        state_d   = S_PRE;
                    end
                end
            end
            S_PRE: begin
                mem_re    = 1'b1;
                mem_raddr = '0;
                rd_addr_d = RD_ONE;
                state_d   = S_STR;
            end
            S_STR: begin
                // rd_addr_q runs one ahead of the index currently on o_seq.
                mem_re    = (rd_addr_q < RD_END);
                rd_addr_d = rd_addr_q + 1'b1;
                if (rd_addr_q == RD_END) begin
                    rd_addr_d  = '0;
                    wait_cnt_d = '0;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_blob_valid) begin
                    count_d       = i_blob_count;
                    timeout_d     = 1'b0;
                    count_valid_d = 1'b1;
                    state_d       = S_IDLE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    timeout_d     = 1'b1;
                    count_valid_d = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_valid       = (state_q == S_STR);
        o_seq         = o_valid & mem_rdata;
        o_busy        = (state_q != S_IDLE);
        o_count       = count_q;
        o_count_valid = count_valid_q;
        o_timeout     = timeout_q;
    end

endmodule

// File: tb/tb_blob_frame_feeder.sv
// Self-checking bench for blob_frame_feeder on a small 8x4 frame with a short timeout;
// burst contents are predicted from the pixel stream by a queue-level capture model.
`timescale 1ns/1ps
module tb_blob_frame_feeder;
    localparam int IMG_COL = 8;
    localparam int IMG_ROW = 4;
    localparam int N       = IMG_COL * IMG_ROW;
    localparam int PIX_W   = 12;
    localparam int TIMEOUT = 16;
    localparam int BOUND   = 1000;

    logic             i_clk;
    logic             i_rst;
    logic             i_start;
    logic [PIX_W-1:0] i_thresh;
    logic             i_pix_valid;
    logic             i_pix_sof;
    logic [PIX_W-1:0] i_pix_gray;
    logic             o_valid;
    logic             o_seq;
    logic             i_blob_valid;
    logic [7:0]       i_blob_count;
    logic             o_busy;
    logic [7:0]       o_count;
    logic             o_count_valid;
    logic             o_timeout;

    blob_frame_feeder #(
        .IMG_COL(IMG_COL),
        .IMG_ROW(IMG_ROW),
        .PIX_W  (PIX_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_thresh     (i_thresh),
        .i_pix_valid  (i_pix_valid),
        .i_pix_sof    (i_pix_sof),
        .i_pix_gray   (i_pix_gray),
        .o_valid      (o_valid),
        .o_seq        (o_seq),
        .i_blob_valid (i_blob_valid),
        .i_blob_count (i_blob_count),
        .o_busy       (o_busy),
        .o_count      (o_count),
        .o_count_valid(o_count_valid),
        .o_timeout    (o_timeout)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic             v;
        logic             s;
        logic [PIX_W-1:0] g;
    } pix_t;

    typedef struct {
        logic [PIX_W-1:0] thr;
        bit               gapped;
        bit               midStart;
        bit               useTimeout;
        int               delay;
        logic [7:0]       blob;
        int               expOnes;
        logic [7:0]       expCount;
        bit               expTimeout;
    } vec_t;

    pix_t       stim[$];
    vec_t       vecs[6];
    int         errors = 0;
    int         checks = 0;
    logic [7:0] modelCount = '0;
    bit         modelTimeout = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic pushPix(input logic v, input logic s, input logic [PIX_W-1:0] g);
        pix_t p;
        p.v = v;
        p.s = s;
        p.g = g;
        stim.push_back(p);
    endtask

    // Expected frame: the last SOF-started run of valid pixels that reaches N entries.
    function automatic logic [N-1:0] modelFrame(input logic [PIX_W-1:0] thr);
        logic [N-1:0] frame;
        int           idx;
        bit           armed;
        bit           done;
        frame = '0;
        idx   = 0;
        armed = 1'b0;
        done  = 1'b0;
        foreach (stim[i]) begin
            if (!done && stim[i].v) begin
                if (stim[i].s) begin
                    armed = 1'b1;
                    idx   = 0;
                end
                if (armed) begin
                    frame[idx] = (stim[i].g >= thr);
                    idx++;
                    if (idx == N) done = 1'b1;
                end
            end
        end
        return frame;
    endfunction

    function automatic logic [PIX_W-1:0] pickGray(input logic [PIX_W-1:0] thr, input bit maxOnly);
        if (maxOnly) return ($urandom_range(0, 1) == 1) ? 12'hFFF : 12'hFFE;
        case ($urandom_range(0, 4))
            0: return thr;
            1: return thr - 1'b1;
            2: return thr + 1'b1;
            3: return 12'hFFF;
            default: return PIX_W'($urandom);
        endcase
    endfunction

    task automatic buildRamp(input bit gapped);
        stim.delete();
        for (int k = 0; k < N; k++) begin
            if (gapped && k > 0) pushPix(1'b0, 1'b0, PIX_W'($urandom));
            pushPix(1'b1, k == 0, PIX_W'(k * 10));
        end
    endtask

    task automatic pushFrame(input int len, input logic [PIX_W-1:0] thr, input bit maxOnly);
        for (int k = 0; k < len; k++) begin
            while ($urandom_range(0, 2) == 0) pushPix(1'b0, 1'($urandom_range(0, 1)), PIX_W'($urandom));
            pushPix(1'b1, k == 0, pickGray(thr, maxOnly));
        end
    endtask

    task automatic buildRandom(input logic [PIX_W-1:0] thr, input bit maxOnly);
        int junk;
        stim.delete();
        junk = $urandom_range(0, 4);
        for (int j = 0; j < junk; j++) begin
            if ($urandom_range(0, 1) == 1) pushPix(1'b1, 1'b0, PIX_W'($urandom));
            else                           pushPix(1'b0, 1'($urandom_range(0, 1)), PIX_W'($urandom));
        end
        if ($urandom_range(0, 1) == 1) pushFrame($urandom_range(1, N - 1), thr, maxOnly);
        pushFrame(N, thr, maxOnly);
        for (int j = $urandom_range(0, 3); j > 0; j--) pushPix(1'b1, 1'($urandom_range(0, 1)), PIX_W'($urandom));
    endtask

    task automatic applyStimulus();
        foreach (stim[i]) begin
            i_pix_valid = stim[i].v;
            i_pix_sof   = stim[i].s;
            i_pix_gray  = stim[i].g;
            @(posedge i_clk);
            #1;
        end
        i_pix_valid = 1'b0;
        i_pix_sof   = 1'b0;
    endtask

    task automatic startMeas(input logic [PIX_W-1:0] thr);
        @(posedge i_clk);
        #1;
        i_start  = 1'b1;
        i_thresh = thr;
        @(posedge i_clk);
        #1;
        i_start  = 1'b0;
        i_thresh = PIX_W'($urandom);
    endtask

    task automatic runMeas(input logic [PIX_W-1:0] thr, input bit midStart, input bit useTimeout,
                           input int delay, input logic [7:0] blob, output logic [N-1:0] got);
        logic [N-1:0] expBits;
        int           len;
        int           n;
        expBits = modelFrame(thr);
        got     = '0;
        len     = 0;
        startMeas(thr);
        fork
            applyStimulus();
            begin
                int w;
                w = 0;
                @(negedge i_clk);
                while (!o_valid && w < BOUND) begin
                    @(negedge i_clk);
                    w++;
                end
                checkOutput("burst_start", o_valid, 1);
                while (o_valid && len < N + 8) begin
                    if (len < N) got[len] = o_seq;
                    i_start = midStart && (len == 5);
                    if (midStart && len == 5) i_thresh = '0;
                    len++;
                    @(negedge i_clk);
                end
                i_start = 1'b0;
            end
        join
        checkOutput("burst_len", len, N);
        checkOutput("burst_bits", got, expBits);
        checkOutput("seq_idle", o_seq, 0);
        checkOutput("busy_wait", o_busy, 1);
        if (!useTimeout) begin
            repeat (delay - 1) @(negedge i_clk);
            i_blob_valid = 1'b1;
            i_blob_count = blob;
            @(negedge i_clk);
            i_blob_valid = 1'b0;
            i_blob_count = 8'($urandom);
            modelCount   = blob;
            modelTimeout = 1'b0;
        end else begin
            n = 0;
            while (o_busy && !o_count_valid && n < BOUND) begin
                n++;
                @(negedge i_clk);
            end
            checkOutput("wait_cycles", n, TIMEOUT);
            modelTimeout = 1'b1;
        end
        checkOutput("pulse", o_count_valid, 1);
        checkOutput("count", o_count, modelCount);
        checkOutput("timeout", o_timeout, modelTimeout);
        checkOutput("busy_done", o_busy, 0);
        @(negedge i_clk);
        checkOutput("pulse_once", o_count_valid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [N-1:0] got;
        i_rst        = 1'b1;
        i_start      = 1'b0;
        i_thresh     = '0;
        i_pix_valid  = 1'b0;
        i_pix_sof    = 1'b0;
        i_pix_gray   = '0;
        i_blob_valid = 1'b0;
        i_blob_count = '0;

        // thr, gapped, midStart, useTimeout, delay, blob, expOnes, expCount, expTimeout
        vecs[0] = '{12'd100,  1'b0, 1'b0, 1'b0, 10, 8'd7,   22, 8'd7,   1'b0};
        vecs[1] = '{12'd100,  1'b1, 1'b1, 1'b1, 0,  8'd0,   22, 8'd7,   1'b1};
        vecs[2] = '{12'd0,    1'b0, 1'b0, 1'b0, 16, 8'd200, 32, 8'd200, 1'b0};
        vecs[3] = '{12'd4095, 1'b1, 1'b0, 1'b0, 1,  8'd255, 0,  8'd255, 1'b0};
        vecs[4] = '{12'd310,  1'b0, 1'b0, 1'b1, 0,  8'd0,   1,  8'd255, 1'b1};
        vecs[5] = '{12'd311,  1'b0, 1'b0, 1'b0, 5,  8'd0,   0,  8'd0,   1'b0};

        repeat (3) @(negedge i_clk);
        checkOutput("rst_valid", o_valid, 0);
        checkOutput("rst_seq", o_seq, 0);
        checkOutput("rst_busy", o_busy, 0);
        checkOutput("rst_count", o_count, 0);
        checkOutput("rst_count_valid", o_count_valid, 0);
        checkOutput("rst_timeout", o_timeout, 0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            buildRamp(vecs[i].gapped);
            runMeas(vecs[i].thr, vecs[i].midStart, vecs[i].useTimeout, vecs[i].delay, vecs[i].blob, got);
            checkOutput("tbl_ones", $countones(got), vecs[i].expOnes);
            checkOutput("tbl_count", o_count, vecs[i].expCount);
            checkOutput("tbl_timeout", o_timeout, vecs[i].expTimeout);
        end

        // Junk before SOF, then a resync SOF at write index 12 with a descending frame.
        stim.delete();
        for (int j = 0; j < 5; j++) pushPix(1'b1, 1'b0, 12'd4000);
        for (int k = 0; k < 12; k++) pushPix(1'b1, k == 0, PIX_W'(k * 10));
        for (int k = 0; k < N; k++) pushPix(1'b1, k == 0, PIX_W'((N - 1 - k) * 10));
        runMeas(12'd100, 1'b0, 1'b0, 3, 8'd42, got);
        checkOutput("resync_bits", got, 32'h003F_FFFF);

        @(negedge i_clk);
        i_blob_valid = 1'b1;
        i_blob_count = 8'd99;
        @(negedge i_clk);
        i_blob_valid = 1'b0;
        checkOutput("idle_blob_pulse", o_count_valid, 0);
        checkOutput("idle_blob_count", o_count, modelCount);

        buildRamp(1'b0);
        startMeas(12'd100);
        fork
            applyStimulus();
            begin
                int w;
                w = 0;
                @(negedge i_clk);
                while (!o_valid && w < BOUND) begin
                    @(negedge i_clk);
                    w++;
                end
                repeat (10) @(negedge i_clk);
            end
        join
        checkOutput("pre_rst_valid", o_valid, 1);
        i_rst = 1'b1;
        #1;
        checkOutput("async_rst_valid", o_valid, 0);
        checkOutput("async_rst_seq", o_seq, 0);
        checkOutput("async_rst_busy", o_busy, 0);
        checkOutput("async_rst_count_valid", o_count_valid, 0);
        checkOutput("async_rst_count", o_count, 0);
        modelCount   = '0;
        modelTimeout = 1'b0;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        checkOutput("post_rst_busy", o_busy, 0);

        for (int r = 0; r < 6; r++) begin
            logic [PIX_W-1:0] thr;
            bit               maxOnly;
            maxOnly = (r == 0);
            thr     = maxOnly ? 12'hFFF : PIX_W'($urandom);
            buildRandom(thr, maxOnly);
            runMeas(thr, 1'b0, $urandom_range(0, 2) == 0, $urandom_range(1, TIMEOUT), 8'($urandom), got);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
